// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/lap/clear FSM, 1/100 s prescaler and 00.00-59.99 BCD counter.
// Define STOPWATCH_BLINK_EN to blink the display (via BLANK) while paused.
module stopwatch_ctrl #(
    parameter int TICK_DIV    = 500000,
    parameter int BLINK_TICKS = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  BTN,
    output logic [15:0] DISP,
    output logic        RUNNING,
    output logic        LAPF,
    output logic        OVF,
    output logic        BLANK
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_STOP} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    lap_q, lap_d;
    logic [15:0]    disp_q, disp_d;
    logic           ovf_q, ovf_d;
    logic           counting;
    logic           tick;
    logic [3:0]     at_lim;
    logic [15:0]    cnt_inc;

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (presc_q == TICK_MAX);

    // Per-digit BCD increment; a digit carries when every lower digit sits at its limit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        localparam logic [3:0] LIM = (gi == 3) ? 4'd5 : 4'd9;
        logic [3:0] dig;
        logic       cin;
        assign dig        = cnt_q[4*gi +: 4];
        assign at_lim[gi] = (dig == LIM);
        if (gi == 0) begin : g_lsd
            assign cin = 1'b1;
        end else begin : g_upper
            assign cin = &at_lim[gi-1:0];
        end
        assign cnt_inc[4*gi +: 4] = (dig > LIM)   ? 4'd0 :
                                    !cin          ? dig  :
                                    (dig == LIM)  ? 4'd0 : dig + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        lap_d   = lap_q;
        if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            cnt_d = cnt_inc;
        end
        // The tick above is applied first; a button action then acts on the ticked value.
        unique case (state_q)
            S_IDLE: begin
                if (BTN[0]) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (BTN[0]) begin
                    state_d = S_STOP;
                end else if (BTN[2]) begin
                    state_d = S_LAP;
                    lap_d   = cnt_d;
                end
            end
            S_LAP: begin
                if (BTN[0]) begin
                    state_d = S_STOP;
                end else if (BTN[2]) begin
                    state_d = S_RUN;
                end
            end
            S_STOP: begin
                if (BTN[0]) begin
                    state_d = S_RUN;
                end else if (BTN[1]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                    lap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        disp_d = (state_q == S_LAP) ? lap_q : cnt_q;
        ovf_d  = tick && (&at_lim);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            lap_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            lap_q   <= lap_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign DISP    = disp_q;
    assign RUNNING = counting;
    assign LAPF    = (state_q == S_LAP);
    assign OVF     = ovf_q;

`ifdef STOPWATCH_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] free_q, free_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          blank_q, blank_d;
    logic          blink_tick;

    assign blink_tick = (free_q == TICK_MAX);

    always_comb begin
        free_d  = blink_tick ? '0 : free_q + PW'(1);
        blink_d = blink_q;
        blank_d = blank_q;
        // Blinking restarts from unblanked whenever STOP is entered or left.
        if ((state_q != S_STOP) || (state_d != S_STOP)) begin
            blink_d = '0;
            blank_d = 1'b0;
        end else if (blink_tick) begin
            if (blink_q == BLINK_MAX) begin
                blink_d = '0;
                blank_d = ~blank_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            free_q  <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
        end else begin
            free_q  <= free_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end

    assign BLANK = blank_q;
`else
    assign BLANK = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer-centisecond reference model feeds a queue
// of expected outputs that a negedge monitor compares against the DUT.
module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int BT = 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LAP  = 2;
    localparam int M_STOP = 3;

    logic        CLK;
    logic        RST;
    logic [2:0]  BTN;
    logic [15:0] DISP;
    logic        RUNNING;
    logic        LAPF;
    logic        OVF;
    logic        BLANK;

    stopwatch_ctrl #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN    (BTN),
        .DISP   (DISP),
        .RUNNING(RUNNING),
        .LAPF   (LAPF),
        .OVF    (OVF),
        .BLANK  (BLANK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] disp;
        logic        running;
        logic        lapf;
        logic        ovf;
        int          st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ovf_seen = 0;

    // Reference model: time kept as whole centiseconds, state as a plain integer.
    int m_state;
    int m_presc;
    int m_cs;
    int m_lap;

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_presc = 0;
        m_cs    = 0;
        m_lap   = 0;
    endtask

    task automatic model_step(input logic [2:0] b);
        exp_t e;
        bit   cnt_on;
        bit   tick;
        e.disp = to_bcd((m_state == M_LAP) ? m_lap : m_cs);
        cnt_on = (m_state == M_RUN) || (m_state == M_LAP);
        tick   = cnt_on && (m_presc == TD - 1);
        e.ovf  = tick && (m_cs == 5999);
        if (cnt_on) m_presc = (m_presc + 1) % TD;
        if (tick)   m_cs = (m_cs + 1) % 6000;
        case (m_state)
            M_IDLE: if (b[0]) begin m_state = M_RUN; m_presc = 0; end
            M_RUN: begin
                if (b[0])      m_state = M_STOP;
                else if (b[2]) begin m_state = M_LAP; m_lap = m_cs; end
            end
            M_LAP: begin
                if (b[0])      m_state = M_STOP;
                else if (b[2]) m_state = M_RUN;
            end
            default: begin
                if (b[0])      m_state = M_RUN;
                else if (b[1]) begin m_state = M_IDLE; m_cs = 0; m_presc = 0; m_lap = 0; end
            end
        endcase
        e.running = (m_state == M_RUN) || (m_state == M_LAP);
        e.lapf    = (m_state == M_LAP);
        e.st      = m_state;
        exp_q.push_back(e);
    endtask

    // One clock with the given button pulse; expectations are queued just after the edge.
    task automatic cycle(input logic [2:0] b);
        BTN = b;
        @(posedge CLK);
        #1;
        model_step(b);
        BTN = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        BTN = 3'b000;
        #1;
        chk("rst_disp",    {16'h0, DISP}, 32'h0);
        chk("rst_running", {31'h0, RUNNING}, 32'h0);
        chk("rst_lapf",    {31'h0, LAPF}, 32'h0);
        chk("rst_ovf",     {31'h0, OVF}, 32'h0);
        chk("rst_blank",   {31'h0, BLANK}, 32'h0);
        #1;
        RST = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("disp",    {16'h0, DISP}, {16'h0, e.disp});
                chk("running", {31'h0, RUNNING}, {31'h0, e.running});
                chk("lapf",    {31'h0, LAPF}, {31'h0, e.lapf});
                chk("ovf",     {31'h0, OVF}, {31'h0, e.ovf});
                if (e.ovf) ovf_seen++;
`ifdef STOPWATCH_BLINK_EN
                if (e.st != M_STOP) chk("blank", {31'h0, BLANK}, 32'h0);
`else
                chk("blank", {31'h0, BLANK}, 32'h0);
`endif
            end
        end
    end

    initial begin : stimulus
        int r;
        RST = 1'b1;
        BTN = 3'b000;
        model_reset();
        repeat (2) @(posedge CLK);
        do_reset();

        // Start, reset mid-run, start again.
        idle(3);
        cycle(3'b001);
        idle(20);
        do_reset();
        cycle(3'b001);
        idle(41);

        // Run through 59.99 -> 00.00 and keep going.
        idle(24100);
        chk("ovf_count", ovf_seen, 1);

        // Lap freeze and resume.
        cycle(3'b100);
        idle(20);
        cycle(3'b100);
        idle(10);

        // Stop, hold, clear; clear while running is ignored.
        cycle(3'b001);
        idle(100);
        cycle(3'b010);
        idle(5);
        cycle(3'b001);
        idle(10);
        cycle(3'b010);
        idle(10);

        // Simultaneous presses in RUN: stop wins.
        cycle(3'b111);
        idle(10);
        cycle(3'b001);
        idle(10);

        // Random single-button presses.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 14);
            if (r < 3) cycle(3'b001 << r);
            else       cycle(3'b000);
        end
        idle(3);
        @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
